regr2w_seq: RTL and testbench

Register-select encoder/serializer: the inverse of the 16-line register-control decoder. Accepts a 16-bit register-control request word (one bit per {register, w} pair, multi-hot allowed), then emits one `{_reg, w}` code per handshake until every set bit has been serviced. Sits between the control unit, which builds multi-register transfer masks, and the register-select decoder path, which consumes one `{_reg, w}` at a time.

---
 rtl/regr2w_seq_if.sv | 26 ++
 rtl/regr2w_seq.sv | 130 +++++++++++++
 tb/tb_regr2w_seq.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/regr2w_seq_if.sv
// Handshake bundle for regr2w_seq: request-word input side and
// one-code-at-a-time {_reg, w} output side.
// slave  : the encoder/serializer view.
// master : the control-unit / consumer view.
interface regr2w_seq_if;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  _reg;
    logic        w;
    logic        last;
    logic [4:0]  remain;
    logic        done;

    modport slave (
        input  req_valid, req, out_ready,
        output req_ready, out_valid, _reg, w, last, remain, done
    );

    modport master (
        output req_valid, req, out_ready,
        input  req_ready, out_valid, _reg, w, last, remain, done
    );
endinterface

// File: rtl/regr2w_seq.sv
// regr2w_seq: register-select encoder/serializer.
// Takes a 16-bit multi-hot register-control mask and emits one {_reg, w}
// code per output handshake. Bit i of the mask maps to code c = 15 - i.
// Optional feature macro: REGR2W_ROUNDROBIN_EN selects round-robin code
// selection (pointer of last emitted code); default is fixed priority,
// lowest code first.
module regr2w_seq (
    input  logic          clk,
    input  logic          rst,
    regr2w_seq_if.slave   bus
);
    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] pend_q, pend_d;
    logic [4:0]  remain_q, remain_d;
    logic        done_q, done_d;
    logic [3:0]  sel_code;
    logic [4:0]  req_count;

    // Number of set bits in the incoming word, loaded into the remain counter on accept.
    always_comb begin
        req_count = 5'd0;
        for (int i = 0; i < 16; i++) begin
            req_count = req_count + 5'(bus.req[i]);
        end
    end

`ifdef REGR2W_ROUNDROBIN_EN
    logic [3:0] ptr_q, ptr_d;
    logic [3:0] cand;

    // Round-robin pick: first pending code at ptr+1, ptr+2, ... (mod 16); smallest offset wins.
    always_comb begin
        sel_code = 4'd0;
        cand     = 4'd0;
        for (int k = 16; k >= 1; k--) begin
            cand = ptr_q + 4'(k);
            if (pend_q[4'd15 - cand]) begin
                sel_code = cand;
            end
        end
    end
`else
    // Fixed-priority pick: lowest pending code, i.e. highest set mask bit.
    always_comb begin
        sel_code = 4'd0;
        for (int c = 15; c >= 0; c--) begin
            if (pend_q[15 - c]) begin
                sel_code = 4'(c);
            end
        end
    end
`endif

    // Next-state logic for the IDLE/EMIT sequencer, pending mask, counter and done pulse.
    always_comb begin
        state_d  = state_q;
        pend_d   = pend_q;
        remain_d = remain_q;
        done_d   = 1'b0;
`ifdef REGR2W_ROUNDROBIN_EN
        ptr_d    = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    if (bus.req != 16'd0) begin
                        pend_d   = bus.req;
                        remain_d = req_count;
                        state_d  = EMIT;
                    end else begin
                        // An empty word is serviced immediately.
                        done_d = 1'b1;
                    end
                end
            end
            EMIT: begin
                if (bus.out_ready) begin
                    pend_d   = pend_q & ~(16'h8000 >> sel_code);
                    remain_d = remain_q - 5'd1;
`ifdef REGR2W_ROUNDROBIN_EN
                    ptr_d    = sel_code;
`endif
                    if (remain_q == 5'd1) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset abandons any word in flight without a done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            pend_q   <= 16'd0;
            remain_q <= 5'd0;
            done_q   <= 1'b0;
`ifdef REGR2W_ROUNDROBIN_EN
            ptr_q    <= 4'd15;
`endif
        end else begin
            state_q  <= state_d;
            pend_q   <= pend_d;
            remain_q <= remain_d;
            done_q   <= done_d;
`ifdef REGR2W_ROUNDROBIN_EN
            ptr_q    <= ptr_d;
`endif
        end
    end

    // Code fields are forced to zero outside EMIT so idle outputs match reset values.
    assign bus.req_ready = (state_q == IDLE);
    assign bus.out_valid = (state_q == EMIT);
    assign bus._reg      = (state_q == EMIT) ? sel_code[3:1] : 3'd0;
    assign bus.w         = (state_q == EMIT) ? sel_code[0] : 1'b0;
    assign bus.last      = (state_q == EMIT) && (remain_q == 5'd1);
    assign bus.remain    = remain_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_regr2w_seq.sv
// Directed testbench for regr2w_seq (default fixed-priority build; the
// round-robin sequence test yields the same codes in both builds).
module tb_regr2w_seq;
    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;

    regr2w_seq_if bus ();

    regr2w_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b1;
        bus.req_valid = 1'b0;
        bus.req = 16'd0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        tests_run++;
        if (bus.req_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_req_ready got %0b want 1", bus.req_ready); end
        tests_run++;
        if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid got %0b want 0", bus.out_valid); end
        tests_run++;
        if ({bus._reg, bus.w, bus.last} !== 5'd0) begin tests_failed++; $display("FAIL reset_code got %0h want 0", {bus._reg, bus.w, bus.last}); end
        tests_run++;
        if (bus.remain !== 5'd0 || bus.done !== 1'b0) begin tests_failed++; $display("FAIL reset_remain_done got %0d/%0b want 0/0", bus.remain, bus.done); end
    endtask

    task automatic test_single();
        bus.req_valid = 1'b1;
        bus.req = 16'h8000;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req = 16'hFFFF;
        tests_run++;
        if ({bus.out_valid, bus.req_ready} !== 2'b10) begin tests_failed++; $display("FAIL single_vld_rdy got %b want 10", {bus.out_valid, bus.req_ready}); end
        tests_run++;
        if ({bus._reg, bus.w} !== 4'h0 || bus.last !== 1'b1 || bus.remain !== 5'd1) begin
            tests_failed++; $display("FAIL single_code got c=%0d last=%0b rem=%0d want c=0 last=1 rem=1", {bus._reg, bus.w}, bus.last, bus.remain);
        end
        @(negedge clk);
        tests_run++;
        if (bus.done !== 1'b1 || bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL single_done got done=%0b vld=%0b want 1/0", bus.done, bus.out_valid); end
        @(negedge clk);
        tests_run++;
        if (bus.done !== 1'b0) begin tests_failed++; $display("FAIL single_done_pulse got %0b want 0", bus.done); end
    endtask

    task automatic test_multi();
        bus.req_valid = 1'b1;
        bus.req = 16'h0005;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        tests_run++;
        if ({bus._reg, bus.w} !== 4'd13 || bus.remain !== 5'd2 || bus.last !== 1'b0) begin
            tests_failed++; $display("FAIL multi_first got c=%0d rem=%0d last=%0b want c=13 rem=2 last=0", {bus._reg, bus.w}, bus.remain, bus.last);
        end
        @(negedge clk);
        tests_run++;
        if ({bus._reg, bus.w} !== 4'd15 || bus.remain !== 5'd1 || bus.last !== 1'b1 || bus.done !== 1'b0) begin
            tests_failed++; $display("FAIL multi_second got c=%0d rem=%0d last=%0b done=%0b want c=15 rem=1 last=1 done=0", {bus._reg, bus.w}, bus.remain, bus.last, bus.done);
        end
        @(negedge clk);
        tests_run++;
        if (bus.done !== 1'b1 || bus.remain !== 5'd0) begin tests_failed++; $display("FAIL multi_done got done=%0b rem=%0d want 1/0", bus.done, bus.remain); end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        bus.req_valid = 1'b1;
        bus.req = 16'hC000;
        bus.out_ready = 1'b0;
        @(negedge clk);
        bus.req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if ({bus._reg, bus.w} !== 4'd0 || bus.remain !== 5'd2 || bus.last !== 1'b0 || bus.out_valid !== 1'b1) begin
                tests_failed++; $display("FAIL bp_hold%0d got c=%0d rem=%0d last=%0b vld=%0b want c=0 rem=2 last=0 vld=1", i, {bus._reg, bus.w}, bus.remain, bus.last, bus.out_valid);
            end
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        tests_run++;
        if ({bus._reg, bus.w} !== 4'd0 || bus.remain !== 5'd2) begin tests_failed++; $display("FAIL bp_release got c=%0d rem=%0d want c=0 rem=2", {bus._reg, bus.w}, bus.remain); end
        @(negedge clk);
        tests_run++;
        if ({bus._reg, bus.w} !== 4'd1 || bus.remain !== 5'd1 || bus.last !== 1'b1) begin
            tests_failed++; $display("FAIL bp_second got c=%0d rem=%0d last=%0b want c=1 rem=1 last=1", {bus._reg, bus.w}, bus.remain, bus.last);
        end
        @(negedge clk);
        tests_run++;
        if (bus.done !== 1'b1) begin tests_failed++; $display("FAIL bp_done got %0b want 1", bus.done); end
        @(negedge clk);
    endtask

    task automatic test_zero();
        bus.req_valid = 1'b1;
        bus.req = 16'h0000;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        tests_run++;
        if (bus.done !== 1'b1 || bus.out_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            tests_failed++; $display("FAIL zero_done got done=%0b vld=%0b rdy=%0b want 1/0/1", bus.done, bus.out_valid, bus.req_ready);
        end
        @(negedge clk);
        tests_run++;
        if (bus.done !== 1'b0 || bus.out_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            tests_failed++; $display("FAIL zero_after got done=%0b vld=%0b rdy=%0b want 0/0/1", bus.done, bus.out_valid, bus.req_ready);
        end
    endtask

    task automatic test_reset_mid();
        bus.req_valid = 1'b1;
        bus.req = 16'hFFFF;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if ({bus._reg, bus.w} !== 4'(i) || bus.remain !== 5'(16 - i)) begin
                tests_failed++; $display("FAIL rstmid_code%0d got c=%0d rem=%0d want c=%0d rem=%0d", i, {bus._reg, bus.w}, bus.remain, i, 16 - i);
            end
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests_run++;
        if (bus.out_valid !== 1'b0 || bus.remain !== 5'd0 || bus.req_ready !== 1'b1 || bus.done !== 1'b0) begin
            tests_failed++; $display("FAIL rstmid_state got vld=%0b rem=%0d rdy=%0b done=%0b want 0/0/1/0", bus.out_valid, bus.remain, bus.req_ready, bus.done);
        end
        @(negedge clk);
        tests_run++;
        if (bus.done !== 1'b0 || bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL rstmid_after got done=%0b vld=%0b want 0/0", bus.done, bus.out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_codes [4];
        exp_codes[0] = 4'd14;
        exp_codes[1] = 4'd15;
        exp_codes[2] = 4'd0;
        exp_codes[3] = 4'd15;
        // Fresh reset so the round-robin pointer (if built) starts at 15.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.req_valid = 1'b1;
        bus.req = 16'h0003;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tests_run++;
            if ({bus._reg, bus.w} !== exp_codes[i] || bus.out_valid !== 1'b1) begin
                tests_failed++; $display("FAIL b2b_code%0d got c=%0d vld=%0b want c=%0d vld=1", i, {bus._reg, bus.w}, bus.out_valid, exp_codes[i]);
            end
            @(negedge clk);
        end
        tests_run++;
        if (bus.done !== 1'b1 || bus.req_ready !== 1'b1) begin tests_failed++; $display("FAIL b2b_gap got done=%0b rdy=%0b want 1/1", bus.done, bus.req_ready); end
        bus.req_valid = 1'b1;
        bus.req = 16'h8001;
        @(negedge clk);
        bus.req_valid = 1'b0;
        for (int i = 2; i < 4; i++) begin
            tests_run++;
            if ({bus._reg, bus.w} !== exp_codes[i] || bus.out_valid !== 1'b1) begin
                tests_failed++; $display("FAIL b2b_code%0d got c=%0d vld=%0b want c=%0d vld=1", i, {bus._reg, bus.w}, bus.out_valid, exp_codes[i]);
            end
            @(negedge clk);
        end
        tests_run++;
        if (bus.done !== 1'b1) begin tests_failed++; $display("FAIL b2b_done got %0b want 1", bus.done); end
        @(negedge clk);
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        rst = 1'b1;
        bus.req_valid = 1'b0;
        bus.req = 16'd0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_multi();
        test_backpressure();
        test_zero();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
